// File: rtl/rs_age_pkg.sv
// Shared definitions for the age-ordered reservation station.
//   - FU_W        : width of an FU-class select for the default four classes
//   - fu_class_e  : FU classes (ALU, LS, MULT, BRANCH)
//   - RS_AGE_ENTRY: one RS entry at the default tag/payload widths
//   - idx_w()     : index width that never collapses to zero bits
package rs_age_pkg;

  localparam int DEF_N_FU      = 4;
  localparam int DEF_PR_W      = 6;
  localparam int DEF_PAYLOAD_W = 128;
  localparam int FU_W          = $clog2(DEF_N_FU);

  typedef enum logic [FU_W-1:0] {
    FU_ALU    = 2'd0,
    FU_LS     = 2'd1,
    FU_MULT   = 2'd2,
    FU_BRANCH = 2'd3
  } fu_class_e;

  typedef struct packed {
    logic                     valid;
    logic [DEF_PR_W-1:0]      src1_pr;
    logic                     src1_rdy;
    logic [DEF_PR_W-1:0]      src2_pr;
    logic                     src2_rdy;
    logic [FU_W-1:0]          fu_sel;
    logic [DEF_PAYLOAD_W-1:0] payload;
  } RS_AGE_ENTRY;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs_age_sel.sv
// Oldest-first multi-grant selector driven by an age matrix.
//   req   [N]   : requesting entries
//   older [N*N] : older[i*N+j] = 1 when entry i is older than entry j
//   grant [W*N] : grant[s*N +: N] is one-hot (or zero) for slot s; slot 0
//                 gets the oldest requester, slot s the oldest remaining
//                 after slots 0..s-1 have been removed
module rs_age_sel #(
  parameter int N = 16,
  parameter int W = 3
) (
  input  logic [N-1:0]   req,
  input  logic [N*N-1:0] older,
  output logic [W*N-1:0] grant
);

  // older_col[i][j] = entry j is older than entry i (self excluded)
  logic [N-1:0] older_col [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      older_col[i] = '0;
      for (int j = 0; j < N; j++) begin
        if (i != j) older_col[i][j] = older[j*N+i];
      end
    end
  end

  for (genvar gs = 0; gs < W; gs++) begin : g_slot
    logic [N-1:0] avail;
    logic [N-1:0] gnt;

    if (gs == 0) begin : g_first
      assign avail = req;
    end else begin : g_next
      assign avail = g_slot[gs-1].avail & ~g_slot[gs-1].gnt;
    end

    // An entry wins when no still-available entry is older than it.
    for (genvar gi = 0; gi < N; gi++) begin : g_ent
      assign gnt[gi] = avail[gi] & ~|(avail & older_col[gi]);
    end

    assign grant[gs*N +: N] = gnt;
  end

endmodule

// File: rtl/rs_age.sv
// Parametrised reservation station with age-matrix, oldest-first issue.
//   clock, reset (sync, active-high), squash (flush all entries)
//   disp_*  : up to DISP_W renamed instructions per cycle, slot 0 oldest;
//             disp_stall[k] set when fewer than k+1 entries are free
//   cdb_*   : CDB_W tag broadcasts, used for wakeup of resident entries
//             and snooped by instructions dispatching in the same cycle
//   fu_stall: per FU class, blocks issue of entries of that class
//   issue_* : up to ISSUE_W instructions per cycle, slot 0 oldest;
//             combinational from state, cdb_* and fu_stall
//   free_count: registered number of invalid entries
module rs_age #(
  parameter  int N_ENTRY   = 16,
  parameter  int DISP_W    = 3,
  parameter  int ISSUE_W   = 3,
  parameter  int CDB_W     = 3,
  parameter  int PR_W      = 6,
  parameter  int N_FU      = 4,
  parameter  int PAYLOAD_W = 128,
  localparam int FU_W      = (N_FU > 1) ? $clog2(N_FU) : 1,
  localparam int CNT_W     = $clog2(N_ENTRY + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash,
  input  logic [DISP_W-1:0]              disp_valid,
  input  logic [DISP_W*PR_W-1:0]         disp_src1_pr,
  input  logic [DISP_W*PR_W-1:0]         disp_src2_pr,
  input  logic [DISP_W-1:0]              disp_src1_rdy,
  input  logic [DISP_W-1:0]              disp_src2_rdy,
  input  logic [DISP_W*FU_W-1:0]         disp_fu_sel,
  input  logic [DISP_W*PAYLOAD_W-1:0]    disp_payload,
  output logic [DISP_W-1:0]              disp_stall,
  input  logic [CDB_W-1:0]               cdb_valid,
  input  logic [CDB_W*PR_W-1:0]          cdb_tag,
  input  logic [N_FU-1:0]                fu_stall,
  output logic [ISSUE_W-1:0]             issue_valid,
  output logic [ISSUE_W*PR_W-1:0]        issue_src1_pr,
  output logic [ISSUE_W*PR_W-1:0]        issue_src2_pr,
  output logic [ISSUE_W*FU_W-1:0]        issue_fu_sel,
  output logic [ISSUE_W*PAYLOAD_W-1:0]   issue_payload,
  output logic [CNT_W-1:0]               free_count
);
  import rs_age_pkg::*;

  localparam int SLOT_W = idx_w(DISP_W);

  // Entry state
  logic [N_ENTRY-1:0]   valid_reg;
  logic [N_ENTRY-1:0]   src1_rdy_reg;
  logic [N_ENTRY-1:0]   src2_rdy_reg;
  logic [PR_W-1:0]      src1_pr_reg  [N_ENTRY];
  logic [PR_W-1:0]      src2_pr_reg  [N_ENTRY];
  logic [FU_W-1:0]      fu_sel_reg   [N_ENTRY];
  logic [PAYLOAD_W-1:0] payload_reg  [N_ENTRY];
  logic [N_ENTRY-1:0]   older_reg    [N_ENTRY];
  logic [N_ENTRY-1:0]   older_next   [N_ENTRY];
  logic [CNT_W-1:0]     free_count_reg;

  logic [N_ENTRY-1:0]   src1_ok;
  logic [N_ENTRY-1:0]   src2_ok;
  logic [N_ENTRY-1:0]   elig;
  logic [N_ENTRY-1:0]   issued;
  logic [N_ENTRY-1:0]   alloc;
  logic [SLOT_W-1:0]    alloc_slot   [N_ENTRY];
  logic [N_ENTRY-1:0]   valid_next;
  logic [CNT_W-1:0]     free_next;
  logic [DISP_W-1:0]    disp_src1_ok;
  logic [DISP_W-1:0]    disp_src2_ok;
  logic [N_ENTRY*N_ENTRY-1:0] older_flat;
  logic [ISSUE_W*N_ENTRY-1:0] grant;

  function automatic logic cdb_hit(input logic [PR_W-1:0]       tag,
                                   input logic [CDB_W-1:0]      vld,
                                   input logic [CDB_W*PR_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_W; c++) begin
      if (vld[c] && tags[c*PR_W +: PR_W] == tag) hit = 1'b1;
    end
    return hit;
  endfunction

  // Classes at or beyond N_FU have no stall bit and are never issued.
  function automatic logic fu_free(input logic [FU_W-1:0] fu,
                                   input logic [N_FU-1:0] st);
    logic ok;
    ok = 1'b0;
    for (int u = 0; u < N_FU; u++) begin
      if (int'(fu) == u) ok = ~st[u];
    end
    return ok;
  endfunction

  assign free_count = free_count_reg;

  // Stall looks only at registered occupancy, never at same-cycle issue.
  always_comb begin
    for (int k = 0; k < DISP_W; k++) begin
      disp_stall[k] = reset | (int'(free_count_reg) < k + 1);
    end
  end

  // Wakeup: stored ready, zero register, or a live broadcast this cycle.
  for (genvar gi = 0; gi < N_ENTRY; gi++) begin : g_wake
    assign src1_ok[gi] = src1_rdy_reg[gi] | (src1_pr_reg[gi] == '0) |
                         cdb_hit(src1_pr_reg[gi], cdb_valid, cdb_tag);
    assign src2_ok[gi] = src2_rdy_reg[gi] | (src2_pr_reg[gi] == '0) |
                         cdb_hit(src2_pr_reg[gi], cdb_valid, cdb_tag);
    assign elig[gi]    = valid_reg[gi] & src1_ok[gi] & src2_ok[gi] &
                         fu_free(fu_sel_reg[gi], fu_stall) & ~squash & ~reset;
  end

  // Dispatching instructions snoop the CDB so a same-cycle broadcast sticks.
  for (genvar gi = 0; gi < DISP_W; gi++) begin : g_snoop
    assign disp_src1_ok[gi] = disp_src1_rdy[gi] |
                              (disp_src1_pr[gi*PR_W +: PR_W] == '0) |
                              cdb_hit(disp_src1_pr[gi*PR_W +: PR_W], cdb_valid, cdb_tag);
    assign disp_src2_ok[gi] = disp_src2_rdy[gi] |
                              (disp_src2_pr[gi*PR_W +: PR_W] == '0) |
                              cdb_hit(disp_src2_pr[gi*PR_W +: PR_W], cdb_valid, cdb_tag);
  end

  // Slot k lands in the k-th lowest-index free entry, whether or not the
  // lower slots are valid.
  always_comb begin
    int rank;
    rank  = 0;
    alloc = '0;
    for (int i = 0; i < N_ENTRY; i++) alloc_slot[i] = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      if (!valid_reg[i]) begin
        if (rank < DISP_W) begin
          if (disp_valid[rank] && !disp_stall[rank] && !squash && !reset) begin
            alloc[i]      = 1'b1;
            alloc_slot[i] = SLOT_W'(rank);
          end
        end
        rank++;
      end
    end
  end

  // A new entry is younger than every resident entry and than lower slots
  // of the same dispatch group; rows/cols of untouched entries hold.
  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) begin
      for (int j = 0; j < N_ENTRY; j++) begin
        older_next[i][j] = older_reg[i][j];
        if (alloc[i] && alloc[j]) older_next[i][j] = (alloc_slot[i] < alloc_slot[j]);
        else if (alloc[i])        older_next[i][j] = 1'b0;
        else if (alloc[j])        older_next[i][j] = valid_reg[i];
        if (i == j)               older_next[i][j] = 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < N_ENTRY; gi++) begin : g_flat
    assign older_flat[gi*N_ENTRY +: N_ENTRY] = older_reg[gi];
  end

  rs_age_sel #(.N(N_ENTRY), .W(ISSUE_W)) u_sel (
    .req   (elig),
    .older (older_flat),
    .grant (grant)
  );

  // Issue mux: grants are one-hot per slot, so OR-ing masked fields is exact
  // and leaves unfilled slots all-zero.
  always_comb begin
    issued        = '0;
    issue_valid   = '0;
    issue_src1_pr = '0;
    issue_src2_pr = '0;
    issue_fu_sel  = '0;
    issue_payload = '0;
    for (int s = 0; s < ISSUE_W; s++) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        if (grant[s*N_ENTRY+i]) begin
          issued[i]                             = 1'b1;
          issue_valid[s]                        = 1'b1;
          issue_src1_pr[s*PR_W +: PR_W]         = issue_src1_pr[s*PR_W +: PR_W] | src1_pr_reg[i];
          issue_src2_pr[s*PR_W +: PR_W]         = issue_src2_pr[s*PR_W +: PR_W] | src2_pr_reg[i];
          issue_fu_sel[s*FU_W +: FU_W]          = issue_fu_sel[s*FU_W +: FU_W] | fu_sel_reg[i];
          issue_payload[s*PAYLOAD_W +: PAYLOAD_W] =
            issue_payload[s*PAYLOAD_W +: PAYLOAD_W] | payload_reg[i];
        end
      end
    end
  end

  always_comb begin
    int busy;
    busy       = 0;
    valid_next = squash ? '0 : (alloc | (valid_reg & ~issued));
    for (int i = 0; i < N_ENTRY; i++) busy += int'(valid_next[i]);
    free_next  = CNT_W'(N_ENTRY - busy);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg      <= '0;
      free_count_reg <= CNT_W'(N_ENTRY);
      for (int i = 0; i < N_ENTRY; i++) older_reg[i] <= '0;
    end else begin
      valid_reg      <= valid_next;
      free_count_reg <= free_next;
      for (int i = 0; i < N_ENTRY; i++) older_reg[i] <= older_next[i];
    end
  end

  // Entry payload storage; only the valid bits and age matrix need reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_ENTRY; i++) begin
      if (alloc[i]) begin
        src1_pr_reg[i]  <= disp_src1_pr[int'(alloc_slot[i])*PR_W +: PR_W];
        src2_pr_reg[i]  <= disp_src2_pr[int'(alloc_slot[i])*PR_W +: PR_W];
        src1_rdy_reg[i] <= disp_src1_ok[alloc_slot[i]];
        src2_rdy_reg[i] <= disp_src2_ok[alloc_slot[i]];
        fu_sel_reg[i]   <= disp_fu_sel[int'(alloc_slot[i])*FU_W +: FU_W];
        payload_reg[i]  <= disp_payload[int'(alloc_slot[i])*PAYLOAD_W +: PAYLOAD_W];
      end else begin
        src1_rdy_reg[i] <= src1_ok[i];
        src2_rdy_reg[i] <= src2_ok[i];
      end
    end
  end

endmodule

// File: tb/tb_rs_age.sv
module tb_rs_age;
  localparam int N_ENTRY = 16, DISP_W = 3, ISSUE_W = 3, CDB_W = 3;
  localparam int PR_W = 6, N_FU = 4, PAYLOAD_W = 128, FU_W = 2, CNT_W = 5;

  localparam logic [FU_W-1:0] ALU  = rs_age_pkg::FU_ALU;
  localparam logic [FU_W-1:0] MULT = rs_age_pkg::FU_MULT;

  logic clock, reset, squash;
  logic [DISP_W-1:0]            disp_valid, disp_src1_rdy, disp_src2_rdy, disp_stall;
  logic [DISP_W*PR_W-1:0]       disp_src1_pr, disp_src2_pr;
  logic [DISP_W*FU_W-1:0]       disp_fu_sel;
  logic [DISP_W*PAYLOAD_W-1:0]  disp_payload;
  logic [CDB_W-1:0]             cdb_valid;
  logic [CDB_W*PR_W-1:0]        cdb_tag;
  logic [N_FU-1:0]              fu_stall;
  logic [ISSUE_W-1:0]           issue_valid;
  logic [ISSUE_W*PR_W-1:0]      issue_src1_pr, issue_src2_pr;
  logic [ISSUE_W*FU_W-1:0]      issue_fu_sel;
  logic [ISSUE_W*PAYLOAD_W-1:0] issue_payload;
  logic [CNT_W-1:0]             free_count;

  rs_age #(.N_ENTRY(N_ENTRY), .DISP_W(DISP_W), .ISSUE_W(ISSUE_W), .CDB_W(CDB_W),
           .PR_W(PR_W), .N_FU(N_FU), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .disp_valid(disp_valid), .disp_src1_pr(disp_src1_pr), .disp_src2_pr(disp_src2_pr),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_fu_sel(disp_fu_sel), .disp_payload(disp_payload), .disp_stall(disp_stall),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .fu_stall(fu_stall),
    .issue_valid(issue_valid), .issue_src1_pr(issue_src1_pr), .issue_src2_pr(issue_src2_pr),
    .issue_fu_sel(issue_fu_sel), .issue_payload(issue_payload), .free_count(free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic idle();
    squash = 0; disp_valid = '0; disp_src1_pr = '0; disp_src2_pr = '0;
    disp_src1_rdy = '0; disp_src2_rdy = '0; disp_fu_sel = '0; disp_payload = '0;
    cdb_valid = '0; cdb_tag = '0; fu_stall = '0;
  endtask

  task automatic disp(input int k, input logic [PR_W-1:0] s1, input logic r1,
                      input logic [PR_W-1:0] s2, input logic r2,
                      input logic [FU_W-1:0] fu, input logic [PAYLOAD_W-1:0] pl);
    disp_valid[k]                       = 1'b1;
    disp_src1_pr[k*PR_W +: PR_W]        = s1;
    disp_src1_rdy[k]                    = r1;
    disp_src2_pr[k*PR_W +: PR_W]        = s2;
    disp_src2_rdy[k]                    = r2;
    disp_fu_sel[k*FU_W +: FU_W]         = fu;
    disp_payload[k*PAYLOAD_W +: PAYLOAD_W] = pl;
  endtask

  task automatic cdb(input int c, input logic [PR_W-1:0] t);
    cdb_valid[c]               = 1'b1;
    cdb_tag[c*PR_W +: PR_W]    = t;
  endtask

  // Advance past the next edge and return the inputs to idle.
  task automatic cyc();
    @(posedge clock);
    #1;
    idle();
  endtask

  function automatic logic [PAYLOAD_W-1:0] pl_at(input int s);
    return issue_payload[s*PAYLOAD_W +: PAYLOAD_W];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    #1;
    check("rst_stall", disp_stall, 3'b111);
    check("rst_issue", issue_valid, 3'b000);
    cyc(); cyc();
    reset = 1'b0;
    #1;
    check("post_rst_free", free_count, 16);
    check("post_rst_stall", disp_stall, 3'b000);

    // Reset and fill: 3 per cycle, nothing ready.
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 3; k++) disp(k, 10, 1'b0, 11, 1'b0, ALU, 128'(c*3 + k + 1));
      #1;
      check("fill_issue", issue_valid, 3'b000);
      cyc();
      check("fill_free", free_count, 128'(13 - 3*c));
    end
    check("one_free_stall", disp_stall, 3'b110);
    disp(0, 10, 1'b0, 11, 1'b0, ALU, 128'h10);
    cyc();
    check("full_free", free_count, 0);
    check("full_stall", disp_stall, 3'b111);
    squash = 1'b1;
    cyc();
    check("clear_free", free_count, 16);

    // Age over index: A at entry 5, B later at entry 2.
    disp(0, 20, 1'b0, 0, 1'b1, ALU, 128'hA0);
    disp(1, 20, 1'b0, 0, 1'b1, ALU, 128'hA1);
    disp(2, 0, 1'b1, 0, 1'b1, ALU, 128'hC2);
    #1;
    check("age_c0_issue", issue_valid, 3'b000);
    cyc();
    check("age_c0_free", free_count, 13);
    disp(0, 20, 1'b0, 0, 1'b1, ALU, 128'hA3);
    disp(1, 20, 1'b0, 0, 1'b1, ALU, 128'hA4);
    disp(2, 30, 1'b0, 0, 1'b1, ALU, 128'hAA);
    #1;
    check("age_c1_issue", issue_valid, 3'b001);
    check("age_c1_pl0", pl_at(0), 128'hC2);
    cyc();
    check("age_c1_free", free_count, 11);
    disp(0, 30, 1'b0, 0, 1'b1, ALU, 128'hBB);
    #1;
    check("age_c2_issue", issue_valid, 3'b000);
    cyc();
    check("age_c2_free", free_count, 10);
    cdb(0, 30);
    #1;
    check("age_c3_issue", issue_valid, 3'b011);
    check("age_c3_pl0_A", pl_at(0), 128'hAA);
    check("age_c3_pl1_B", pl_at(1), 128'hBB);
    check("age_c3_pl2_zero", pl_at(2), 128'h0);
    cyc();
    check("age_c3_free", free_count, 12);

    // Squash with residents that the CDB would make ready, plus dispatches.
    squash = 1'b1;
    cdb(0, 20);
    for (int k = 0; k < 3; k++) disp(k, 0, 1'b1, 0, 1'b1, ALU, 128'hEE);
    #1;
    check("squash_issue", issue_valid, 3'b000);
    cyc();
    check("squash_free", free_count, 16);
    check("squash_next_issue", issue_valid, 3'b000);

    // Zero-cycle wakeup of a resident, snoop for a dispatching entry.
    disp(0, 7, 1'b0, 0, 1'b0, ALU, 128'hD0);
    cyc();
    #1;
    check("wake_wait_p7", issue_valid, 3'b000);
    cyc();
    cdb(0, 7);
    cdb(1, 9);
    disp(0, 9, 1'b0, 0, 1'b1, ALU, 128'hD1);
    #1;
    check("wake_same_issue", issue_valid, 3'b001);
    check("wake_same_pl", pl_at(0), 128'hD0);
    check("wake_same_src1", issue_src1_pr[0 +: PR_W], 7);
    cyc();
    #1;
    check("snoop_issue", issue_valid, 3'b001);
    check("snoop_pl", pl_at(0), 128'hD1);
    cyc();
    check("snoop_free", free_count, 16);

    // CDB valid gating; zero-tag sources are always ready.
    disp(0, 4, 1'b0, 0, 1'b1, ALU, 128'hE0);
    disp(1, 0, 1'b0, 0, 1'b0, ALU, 128'hE1);
    cyc();
    cdb_tag[0 +: PR_W] = 6'd4;
    #1;
    check("gate_issue", issue_valid, 3'b001);
    check("gate_pl_zero_tag", pl_at(0), 128'hE1);
    cyc();
    #1;
    check("gate_still_wait", issue_valid, 3'b000);
    cyc();
    cdb(2, 4);
    #1;
    check("gate_wake_issue", issue_valid, 3'b001);
    check("gate_wake_pl", pl_at(0), 128'hE0);
    cyc();

    // FU stall: three MULTs held back, the younger ALU entry goes first.
    for (int k = 0; k < 3; k++) disp(k, 12, 1'b1, 13, 1'b1, MULT, 128'(8'hF0 + k));
    fu_stall[2] = 1'b1;
    cyc();
    disp(0, 12, 1'b1, 13, 1'b1, ALU, 128'hF3);
    fu_stall[2] = 1'b1;
    #1;
    check("fu_mult_blocked", issue_valid, 3'b000);
    cyc();
    fu_stall[2] = 1'b1;
    #1;
    check("fu_alu_issue", issue_valid, 3'b001);
    check("fu_alu_pl", pl_at(0), 128'hF3);
    check("fu_alu_sel", issue_fu_sel, {2'd0, 2'd0, ALU});
    cyc();
    #1;
    check("fu_mult_issue", issue_valid, 3'b111);
    check("fu_mult_pl0", pl_at(0), 128'hF0);
    check("fu_mult_pl1", pl_at(1), 128'hF1);
    check("fu_mult_pl2", pl_at(2), 128'hF2);
    check("fu_mult_sel", issue_fu_sel, {MULT, MULT, MULT});
    cyc();
    #1;
    check("fu_done_issue", issue_valid, 3'b000);
    check("fu_done_free", free_count, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
